uart_cmd_tx: RTL and testbench

- Command frame transmitter: the host/test end of the UART control protocol used by the scaler's configuration receiver.
- Accepts one configuration command at a time (output size, video format, algorithm, BiCubic coefficient a) and serializes it into the receiver's byte frame.
- Drives a byte-level UART transmitter through a start/done handshake.
- Used on the loopback/self-test board and as the BFM-equivalent on the companion FPGA.

---
 rtl/uart_cmd_tx_if.sv | 24 ++
 rtl/uart_cmd_tx.sv | 171 +++++++++++++++++
 tb/tb_uart_cmd_tx.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_tx_if.sv
// Command handshake between the configuration host and the frame transmitter.
// The master side issues one command at a time; the slave reports readiness.
interface uart_cmd_tx_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [11:0] cmd_x_pix;
    logic [11:0] cmd_y_pix;
    logic        cmd_vid_format;
    logic [1:0]  cmd_algorithm;
    logic [8:0]  cmd_bi_a;

    modport master (
        output cmd_valid, cmd_type, cmd_x_pix, cmd_y_pix,
               cmd_vid_format, cmd_algorithm, cmd_bi_a,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_x_pix, cmd_y_pix,
               cmd_vid_format, cmd_algorithm, cmd_bi_a,
        output cmd_ready
    );
endinterface

// File: rtl/uart_cmd_tx.sv
// Serializes one scaler configuration command into the receiver's AA 55 byte frame
// and feeds it byte by byte to a UART byte transmitter via a start/done handshake.
module uart_cmd_tx #(
    parameter int X_MIN        = 161,
    parameter int X_MAX        = 1920,
    parameter int Y_MIN        = 121,
    parameter int Y_MAX        = 1080,
    parameter int BYTE_GAP     = 16,
    parameter int DONE_TIMEOUT = 100000
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    uart_cmd_tx_if.slave cmd,
    output logic         uart_tx_en,
    output logic [7:0]   uart_tx_data,
    input  logic         uart_tx_done,
    output logic         frame_done,
    output logic         frame_err,
    output logic         busy
);
    localparam int CNT_MAX = (DONE_TIMEOUT > BYTE_GAP) ? DONE_TIMEOUT : BYTE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_buf [6];
    logic [2:0]       r_idx;
    logic [2:0]       r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tx_data;

    logic             w_last;
    logic             w_tmo_hit;
    logic             w_gap_end;
    logic [11:0]      w_x;
    logic [11:0]      w_y;

    function automatic logic [11:0] clamp(input logic [11:0] v, input int lo, input int hi);
        if (int'(v) <= lo)
            return 12'(lo);
        else if (int'(v) >= hi)
            return 12'(hi);
        else
            return v;
    endfunction

    assign w_x       = clamp(cmd.cmd_x_pix, X_MIN, X_MAX);
    assign w_y       = clamp(cmd.cmd_y_pix, Y_MIN, Y_MAX);
    assign w_last    = (r_idx == r_len - 3'd1);
    assign w_tmo_hit = (r_cnt == CNT_W'(DONE_TIMEOUT - 1));
    // With no gap configured the counter is never consulted; GAP is skipped entirely.
    assign w_gap_end = (BYTE_GAP == 0) ? 1'b1 : (r_cnt == CNT_W'(BYTE_GAP - 1));

    assign cmd.cmd_ready = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign uart_tx_data  = r_tx_data;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        uart_tx_en = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        unique case (r_state)
            S_IDLE: if (cmd.cmd_valid) w_next = S_LOAD;
            S_LOAD: w_next = S_SEND;
            S_SEND: begin
                uart_tx_en = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (uart_tx_done) begin
                    if (BYTE_GAP == 0)
                        w_next = w_last ? S_DONE : S_LOAD;
                    else
                        w_next = S_GAP;
                end else if (w_tmo_hit) begin
                    frame_err = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_GAP: if (w_gap_end) w_next = w_last ? S_DONE : S_LOAD;
            S_DONE: begin
                frame_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_idx     <= 3'd0;
            r_len     <= 3'd0;
            r_cnt     <= '0;
            r_tx_data <= 8'h00;
            for (int i = 0; i < 6; i++) r_buf[i] <= 8'h00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        r_idx    <= 3'd0;
                        r_cnt    <= '0;
                        r_buf[0] <= 8'hAA;
                        r_buf[1] <= 8'h55;
                        unique case (cmd.cmd_type)
                            2'd0: begin
                                r_buf[2] <= {4'h0, w_x[11:8]};
                                r_buf[3] <= w_x[7:0];
                                r_buf[4] <= {4'h0, w_y[11:8]};
                                r_buf[5] <= w_y[7:0];
                                r_len    <= 3'd6;
                            end
                            2'd1: begin
                                r_buf[2] <= 8'hCF;
                                r_buf[3] <= {7'b0, cmd.cmd_vid_format};
                                r_buf[4] <= 8'h00;
                                r_buf[5] <= 8'h00;
                                r_len    <= 3'd4;
                            end
                            2'd2: begin
                                r_buf[2] <= 8'h3F;
                                r_buf[3] <= {6'b0, cmd.cmd_algorithm};
                                r_buf[4] <= 8'h00;
                                r_buf[5] <= 8'h00;
                                r_len    <= 3'd4;
                            end
                            default: begin
                                r_buf[2] <= 8'hAF;
                                r_buf[3] <= {7'b0, cmd.cmd_bi_a[8]};
                                r_buf[4] <= cmd.cmd_bi_a[7:0];
                                r_buf[5] <= 8'h00;
                                r_len    <= 3'd5;
                            end
                        endcase
                    end
                end
                S_LOAD: r_tx_data <= r_buf[r_idx];
                S_SEND: r_cnt <= '0;
                S_WAIT: begin
                    if (uart_tx_done) begin
                        r_cnt <= '0;
                        if (BYTE_GAP == 0 && !w_last) r_idx <= r_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_cnt <= '0;
                        if (!w_last) r_idx <= r_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: r_idx <= 3'd0;
                default: r_idx <= 3'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_tx.sv
// Scoreboard bench for uart_cmd_tx: a byte-transmitter model answers each start pulse,
// and a monitor pops expected bytes/frame events as the DUT presents them.
module tb_uart_cmd_tx;
    localparam int BYTE_GAP     = 16;
    localparam int DONE_TIMEOUT = 200;
    localparam int TX_LAT       = 20;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_done;
    logic       frame_done;
    logic       frame_err;
    logic       busy;
    logic       model_done = 1'b0;
    logic       spur_done  = 1'b0;

    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int en_count    = 0;
    int done_count  = 0;
    int withhold_at = -1;
    int last_done   = -1;
    int last_en_cyc = 0;

    logic [7:0] exp_q [$];
    int         ev_q  [$];

    uart_cmd_tx_if cmd_if ();

    assign uart_tx_done = model_done | spur_done;

    uart_cmd_tx #(
        .BYTE_GAP     (BYTE_GAP),
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .cmd          (cmd_if.slave),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_done (uart_tx_done),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    initial forever #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Bytes are packed MSB-first; only the top n bytes are queued.
    task automatic expect_frame(input logic [47:0] bytes, input int n, input int ev);
        for (int i = 0; i < n; i++) exp_q.push_back(bytes[47 - 8*i -: 8]);
        if (ev >= 0) ev_q.push_back(ev);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_if.cmd_ready && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        check("cmd_ready_wait", cmd_if.cmd_ready, 1);
    endtask

    task automatic send_cmd(input logic [1:0] t, input logic [11:0] x, input logic [11:0] y,
                            input logic vf, input logic [1:0] alg, input logic [8:0] a);
        wait_ready();
        cmd_if.cmd_valid      = 1'b1;
        cmd_if.cmd_type       = t;
        cmd_if.cmd_x_pix      = x;
        cmd_if.cmd_y_pix      = y;
        cmd_if.cmd_vid_format = vf;
        cmd_if.cmd_algorithm  = alg;
        cmd_if.cmd_bi_a       = a;
        @(negedge sys_clk);
        cmd_if.cmd_valid      = 1'b0;
        cmd_if.cmd_type       = ~t;
        cmd_if.cmd_x_pix      = ~x;
        cmd_if.cmd_y_pix      = ~y;
        cmd_if.cmd_vid_format = ~vf;
        cmd_if.cmd_algorithm  = ~alg;
        cmd_if.cmd_bi_a       = ~a;
        @(negedge sys_clk);
        check("accept_to_en", uart_tx_en, 1);
    endtask

    // Byte transmitter model: answers each start pulse with done after TX_LAT cycles.
    initial begin
        logic [7:0] cap;
        bit hold_ok;
        bit aborted;
        forever begin
            @(negedge sys_clk);
            if (uart_tx_en && !sys_rst) begin
                cap = uart_tx_data;
                en_count++;
                hold_ok = 1'b1;
                aborted = 1'b0;
                if (en_count == withhold_at) continue;
                for (int i = 0; i < TX_LAT; i++) begin
                    @(negedge sys_clk);
                    if (sys_rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (uart_tx_data !== cap) hold_ok = 1'b0;
                end
                if (!aborted) begin
                    check("data_hold", hold_ok, 1);
                    model_done = 1'b1;
                    last_done  = cyc;
                    done_count++;
                    @(negedge sys_clk);
                    model_done = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge sys_clk) begin
        if (uart_tx_en) begin
            check("en_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("tx_byte", uart_tx_data, exp_q.pop_front());
            if (last_done >= 0) check("byte_gap", (cyc - last_done) >= BYTE_GAP + 2, 1);
            last_en_cyc = cyc;
        end
        if (frame_done || frame_err) begin
            check("event_expected", ev_q.size() != 0, 1);
            if (ev_q.size() != 0) check("event_kind", frame_err ? 1 : 0, ev_q.pop_front());
            if (frame_err) check("timeout_cycles", cyc - last_en_cyc, DONE_TIMEOUT);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        sys_rst               = 1'b1;
        cmd_if.cmd_valid      = 1'b0;
        cmd_if.cmd_type       = 2'd0;
        cmd_if.cmd_x_pix      = 12'd0;
        cmd_if.cmd_y_pix      = 12'd0;
        cmd_if.cmd_vid_format = 1'b0;
        cmd_if.cmd_algorithm  = 2'd0;
        cmd_if.cmd_bi_a       = 9'd0;
        repeat (3) @(negedge sys_clk);
        check("rst_ready", cmd_if.cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_en", uart_tx_en, 0);
        check("rst_data", uart_tx_data, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // 1280x720
        expect_frame(48'hAA55_0500_02D0, 6, 0);
        send_cmd(2'd0, 12'd1280, 12'd720, 1'b0, 2'd0, 9'd0);
        check("busy_in_frame", busy, 1);
        check("ready_in_frame", cmd_if.cmd_ready, 0);
        wait_ready();

        // Clamped 100x2000 -> 161x1080
        expect_frame(48'hAA55_00A1_0438, 6, 0);
        send_cmd(2'd0, 12'd100, 12'd2000, 1'b0, 2'd0, 9'd0);
        wait_ready();

        // Back-to-back bi_a, vid_format, algorithm
        expect_frame(48'hAA55_AF01_8000, 5, 0);
        send_cmd(2'd3, 12'd0, 12'd0, 1'b0, 2'd0, 9'h180);
        expect_frame(48'hAA55_CF01_0000, 4, 0);
        send_cmd(2'd1, 12'd0, 12'd0, 1'b1, 2'd0, 9'd0);
        expect_frame(48'hAA55_3F02_0000, 4, 0);
        send_cmd(2'd2, 12'd0, 12'd0, 1'b0, 2'd2, 9'd0);
        expect_frame(48'hAA55_3F03_0000, 4, 0);
        send_cmd(2'd2, 12'd0, 12'd0, 1'b0, 2'd3, 9'd0);
        wait_ready();

        // Done withheld on byte 3 -> timeout abort, no 4th byte
        withhold_at = en_count + 3;
        expect_frame(48'hAA55_0500_02D0, 3, 1);
        send_cmd(2'd0, 12'd1280, 12'd720, 1'b0, 2'd0, 9'd0);
        wait_ready();
        withhold_at = -1;

        // Reset during WAIT of byte 2
        base = en_count;
        expect_frame(48'hAA55_0500_02D0, 6, -1);
        send_cmd(2'd0, 12'd1280, 12'd720, 1'b0, 2'd0, 9'd0);
        n = 0;
        while (en_count < base + 2 && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        check("reach_byte2", en_count, base + 2);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_ready", cmd_if.cmd_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_en", uart_tx_en, 0);
        check("midrst_data", uart_tx_data, 0);
        check("midrst_done", frame_done, 0);
        check("midrst_err", frame_err, 0);
        sys_rst = 1'b0;
        exp_q.delete();
        @(negedge sys_clk);
        expect_frame(48'hAA55_3F01_0000, 4, 0);
        send_cmd(2'd2, 12'd0, 12'd0, 1'b0, 2'd1, 9'd0);
        wait_ready();

        // cmd_valid while busy and spurious done in GAP are ignored
        base = done_count;
        expect_frame(48'hAA55_077F_007A, 6, 0);
        send_cmd(2'd0, 12'd1919, 12'd122, 1'b0, 2'd0, 9'd0);
        n = 0;
        while (done_count < base + 1 && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        check("reach_gap", done_count, base + 1);
        repeat (4) @(negedge sys_clk);
        spur_done             = 1'b1;
        cmd_if.cmd_valid      = 1'b1;
        cmd_if.cmd_type       = 2'd0;
        cmd_if.cmd_x_pix      = 12'h123;
        cmd_if.cmd_y_pix      = 12'h321;
        check("ready_while_busy", cmd_if.cmd_ready, 0);
        @(negedge sys_clk);
        spur_done = 1'b0;
        @(negedge sys_clk);
        cmd_if.cmd_valid = 1'b0;
        wait_ready();

        repeat (5) @(negedge sys_clk);
        check("bytes_drained", exp_q.size(), 0);
        check("events_drained", ev_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
